// File: rtl/implication_queue.sv
`default_nettype none
// ============================================================================
// Module      : implication_queue
// Description : Buffers unit-clause implications. Drops duplicates, latches
//               the first conflicting implication and presents the rest FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module implication_queue #(
  parameter int NUM_VARIABLE = 128,
  parameter int DEPTH        = 16,
  localparam int VAR_W       = $clog2(NUM_VARIABLE),
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [VAR_W-1:0] in_var_i,
  input  logic             in_value_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [VAR_W-1:0] out_var_o,
  output logic             out_value_o,
  input  logic             out_ready_i,
  output logic             conflict_o,
  output logic [VAR_W-1:0] conflict_var_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int ENTRY_W = VAR_W + 1;

  logic [ENTRY_W-1:0]      mem_q [DEPTH];
  logic [ENTRY_W-1:0]      mem_d [DEPTH];
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [NUM_VARIABLE-1:0] pending_q, pending_d;
  logic [NUM_VARIABLE-1:0] pending_val_q, pending_val_d;
  logic                    conflict_q, conflict_d;
  logic [VAR_W-1:0]        conflict_var_q, conflict_var_d;

  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic [VAR_W-1:0]        head_var;
  logic                    head_val;
  logic                    pend_after_pop;
  logic                    push_new;
  logic                    push_conflict;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign in_ready_o  = !full && !conflict_q;
  assign out_valid_o = !empty && !conflict_q;

  assign {head_var, head_val} = mem_q[rd_ptr_q];

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  // Classification sees the pending map with any same-cycle pop already
  // retired, so re-pushing the departing head variable counts as new.
  assign pend_after_pop = pending_q[in_var_i] && !(pop && (head_var == in_var_i));
  assign push_new       = push && !pend_after_pop;
  assign push_conflict  = push && pend_after_pop && (pending_val_q[in_var_i] != in_value_i);

  always_comb begin
    mem_d          = mem_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    pending_d      = pending_q;
    pending_val_d  = pending_val_q;
    conflict_d     = conflict_q;
    conflict_var_d = conflict_var_q;
    count_d        = count_q + CNT_W'(push_new) - CNT_W'(pop);

    if (pop) begin
      rd_ptr_d            = rd_ptr_q + PTR_W'(1);
      pending_d[head_var] = 1'b0;
    end

    if (push_new) begin
      mem_d[wr_ptr_q]          = {in_var_i, in_value_i};
      wr_ptr_d                 = wr_ptr_q + PTR_W'(1);
      pending_d[in_var_i]      = 1'b1;
      pending_val_d[in_var_i]  = in_value_i;
    end

    // Only reachable while conflict_q is clear, so the first offender sticks.
    if (push_conflict) begin
      conflict_d     = 1'b1;
      conflict_var_d = in_var_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      mem_q          <= '{default: '0};
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      pending_q      <= '0;
      pending_val_q  <= '0;
      conflict_q     <= 1'b0;
      conflict_var_q <= '0;
    end else begin
      mem_q          <= mem_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      pending_q      <= pending_d;
      pending_val_q  <= pending_val_d;
      conflict_q     <= conflict_d;
      conflict_var_q <= conflict_var_d;
    end
  end

  assign out_var_o      = head_var;
  assign out_value_o    = head_val;
  assign conflict_o     = conflict_q;
  assign conflict_var_o = conflict_var_q;
  assign count_o        = count_q;
  assign empty_o        = empty;
  assign full_o         = full;

endmodule
`default_nettype wire

// File: tb/tb_implication_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_implication_queue
// Description : Directed plus randomized bench with a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_implication_queue;

  localparam int NUM_VARIABLE = 128;
  localparam int DEPTH        = 16;
  localparam int VAR_W        = 7;
  localparam int CNT_W        = 5;

  logic             clock_i = 1'b0;
  logic             reset_i;
  logic             flush_i;
  logic             in_valid_i;
  logic [VAR_W-1:0] in_var_i;
  logic             in_value_i;
  logic             in_ready_o;
  logic             out_valid_o;
  logic [VAR_W-1:0] out_var_o;
  logic             out_value_o;
  logic             out_ready_i;
  logic             conflict_o;
  logic [VAR_W-1:0] conflict_var_o;
  logic [CNT_W-1:0] count_o;
  logic             empty_o;
  logic             full_o;

  implication_queue #(
    .NUM_VARIABLE(NUM_VARIABLE),
    .DEPTH       (DEPTH)
  ) dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_var_i      (in_var_i),
    .in_value_i    (in_value_i),
    .in_ready_o    (in_ready_o),
    .out_valid_o   (out_valid_o),
    .out_var_o     (out_var_o),
    .out_value_o   (out_value_o),
    .out_ready_i   (out_ready_i),
    .conflict_o    (conflict_o),
    .conflict_var_o(conflict_var_o),
    .count_o       (count_o),
    .empty_o       (empty_o),
    .full_o        (full_o)
  );

  always #5 clock_i = ~clock_i;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  // Reference: pending entries in arrival order, each {var, value}.
  logic [VAR_W:0]   mq[$];
  bit               m_conf = 1'b0;
  logic [VAR_W-1:0] m_cvar = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit push_ok;
    bit pop;
    int idx;
    if (reset_i || flush_i) begin
      mq.delete();
      m_conf = 1'b0;
      m_cvar = '0;
    end else begin
      push_ok = in_valid_i && (mq.size() < DEPTH) && !m_conf;
      pop     = (mq.size() > 0) && !m_conf && out_ready_i;
      if (pop) void'(mq.pop_front());
      if (push_ok) begin
        idx = -1;
        foreach (mq[k]) if (mq[k][VAR_W:1] == in_var_i) idx = k;
        if (idx < 0) mq.push_back({in_var_i, in_value_i});
        else if (mq[idx][0] != in_value_i) begin
          m_conf = 1'b1;
          m_cvar = in_var_i;
        end
      end
    end
  endfunction

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clock_i) begin
    if (armed) begin
      chk("count",        int'(count_o),        mq.size());
      chk("empty",        int'(empty_o),        int'(mq.size() == 0));
      chk("full",         int'(full_o),         int'(mq.size() == DEPTH));
      chk("in_ready",     int'(in_ready_o),     int'(mq.size() < DEPTH && !m_conf));
      chk("out_valid",    int'(out_valid_o),    int'(mq.size() > 0 && !m_conf));
      chk("conflict",     int'(conflict_o),     int'(m_conf));
      chk("conflict_var", int'(conflict_var_o), int'(m_cvar));
      if (mq.size() > 0 && !m_conf) begin
        chk("out_var",   int'(out_var_o),   int'(mq[0][VAR_W:1]));
        chk("out_value", int'(out_value_o), int'(mq[0][0]));
      end
    end
  end

  task automatic step(input bit v, input int vi, input bit val,
                      input bit ordy, input bit fl, input bit rs);
    in_valid_i  = v;
    in_var_i    = VAR_W'(vi);
    in_value_i  = val;
    out_ready_i = ordy;
    flush_i     = fl;
    reset_i     = rs;
    @(posedge clock_i);
    model_step();
    if (rs) armed = 1'b1;
    #1;
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 1);
    chk("rst_in_ready", int'(in_ready_o), 1);
    chk("rst_out_valid", int'(out_valid_o), 0);
    chk("rst_out_var", int'(out_var_o), 0);
    chk("rst_empty", int'(empty_o), 1);

    // Single push then duplicate.
    step(1, 5, 1, 0, 0, 0);
    chk("t1_out_valid", int'(out_valid_o), 1);
    chk("t1_out_var", int'(out_var_o), 5);
    chk("t1_out_value", int'(out_value_o), 1);
    chk("t1_count", int'(count_o), 1);
    step(1, 5, 1, 0, 0, 0);
    chk("t1_dup_count", int'(count_o), 1);
    chk("t1_model_pin", mq.size(), 1);

    // Conflict and flush recovery.
    step(0, 0, 0, 0, 1, 0);
    step(1, 7, 0, 0, 0, 0);
    step(1, 7, 1, 0, 0, 0);
    chk("t2_conflict", int'(conflict_o), 1);
    chk("t2_conflict_var", int'(conflict_var_o), 7);
    chk("t2_in_ready", int'(in_ready_o), 0);
    chk("t2_out_valid", int'(out_valid_o), 0);
    chk("t2_count", int'(count_o), 1);
    step(0, 0, 0, 1, 1, 0);
    chk("t2_flush_conflict", int'(conflict_o), 0);
    chk("t2_flush_count", int'(count_o), 0);
    chk("t2_flush_in_ready", int'(in_ready_o), 1);

    // Fill to full, then hold an offer that must not be taken.
    for (int i = 0; i < DEPTH; i++) step(1, i, 0, 0, 0, 0);
    chk("t3_full", int'(full_o), 1);
    chk("t3_count", int'(count_o), 16);
    chk("t3_in_ready", int'(in_ready_o), 0);
    step(1, 20, 0, 0, 0, 0);
    step(1, 20, 0, 0, 0, 0);
    chk("t3_hold_count", int'(count_o), 16);

    // Drain in order, then stream through the pointer wrap.
    for (int i = 0; i < DEPTH; i++) begin
      chk("t4_head", int'(out_var_o), i);
      step(0, 0, 0, 1, 0, 0);
    end
    chk("t4_empty", int'(empty_o), 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 30 + i, i[0], 1, 0, 0);
      chk("t4_wrap_head", int'(out_var_o), 30 + i);
    end
    step(0, 0, 0, 1, 0, 0);
    chk("t4_wrap_empty", int'(empty_o), 1);

    // Pop and re-push of the same variable with the opposite value.
    step(0, 0, 0, 0, 1, 0);
    step(1, 9, 1, 0, 0, 0);
    step(1, 9, 0, 1, 0, 0);
    chk("t5_conflict", int'(conflict_o), 0);
    chk("t5_out_var", int'(out_var_o), 9);
    chk("t5_out_value", int'(out_value_o), 0);
    chk("t5_count", int'(count_o), 1);

    // Reset mid-operation wipes queue and pending map.
    step(0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 1);
    chk("t6_count", int'(count_o), 0);
    chk("t6_out_valid", int'(out_valid_o), 0);
    chk("t6_conflict", int'(conflict_o), 0);
    step(1, 2, 1, 0, 0, 0);
    chk("t6_new_conflict", int'(conflict_o), 0);
    chk("t6_new_count", int'(count_o), 1);
    chk("t6_new_value", int'(out_value_o), 1);

    // Randomized traffic: small variable range to exercise DUP/CONFLICT.
    for (int c = 0; c < 4000; c++) begin
      int  vi;
      bit  slow;
      vi   = $urandom_range(0, 23);
      slow = ((c / 250) % 2) == 1;
      step($urandom_range(0, 3) != 0,
           vi,
           1'(vi) ^ ($urandom_range(0, 15) == 0),
           slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 499) == 0);
    end

    @(negedge clock_i);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/implication_queue.md
Name: implication_queue

Overview:
- Sits directly downstream of the unit clause evaluator in sat_solver.
- Each cycle it accepts at most one implied assignment (variable index, polarity) from the evaluator. It drops duplicates, detects conflicting implications, and buffers accepted implications in a FIFO.
- The propagation controller drains the FIFO to commit assignments to the variable table.
- A conflict, meaning the same variable is implied with both polarities while pending, is latched and reported to the backtrack logic.

Parameters:
- NUM_VARIABLE, 128, number of solver variables; VARIABLE_INDEX = $clog2(NUM_VARIABLE)-1.
- DEPTH, 16, FIFO entries; power of two, at least 2; PTR_W = $clog2(DEPTH); CNT_W = $clog2(DEPTH+1).

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- flush, input, 1, synchronous clear of queue, pending map and conflict (used on backtrack).
- in_valid, input, 1, implication offered (evaluator is_unit_clause).
- in_var, input, VARIABLE_INDEX+1, implied variable index.
- in_value, input, 1, implied polarity (evaluator new_assignment).
- in_ready, output, 1, queue can accept an implication this cycle.
- out_valid, output, 1, head entry available.
- out_var, output, VARIABLE_INDEX+1, head variable index.
- out_value, output, 1, head polarity.
- out_ready, input, 1, consumer takes the head this cycle.
- conflict, output, 1, sticky conflict flag.
- conflict_var, output, VARIABLE_INDEX+1, variable that caused the first conflict.
- count, output, CNT_W, number of entries in the FIFO.
- empty, output, 1, count == 0.
- full, output, 1, count == DEPTH.

Behaviour:
- State:
  - FIFO storage DEPTH x (VARIABLE_INDEX+2) bits.
  - rd_ptr and wr_ptr, PTR_W bits each, wrap modulo DEPTH.
  - count.
  - pending[NUM_VARIABLE] and pending_val[NUM_VARIABLE] bitmaps.
  - conflict and conflict_var registers.
- Reset (reset=1):
  - Pointers, count, pending, pending_val, conflict and conflict_var all clear to 0.
  - Outputs after reset: in_ready=1, out_valid=0, out_var=0, out_value=0, conflict=0, conflict_var=0, count=0, empty=1, full=0.
- Priority:
  - reset has priority over flush.
  - flush has priority over push and pop.
  - flush produces the same state as reset, but is functionally separate.
- Handshakes:
  - in_ready = !full && !conflict.
  - A push occurs when in_valid && in_ready.
  - out_valid = !empty && !conflict.
  - A pop occurs when out_valid && out_ready.
  - out_var and out_value always show the mem[rd_ptr] contents; they are only meaningful when out_valid=1.
- Pop:
  - rd_ptr increments.
  - pending[out_var] clears.
- Push classification uses the pending state as it stands after any same-cycle pop has been applied:
  - NEW (pending[in_var]=0): write {in_var,in_value} at wr_ptr, wr_ptr increments, set pending[in_var] and pending_val[in_var]=in_value.
  - DUP (pending=1 and pending_val==in_value): accepted and discarded; no FIFO change.
  - CONFLICT (pending=1 and pending_val!=in_value): accepted and not enqueued; conflict goes to 1 and conflict_var=in_var.
- Simultaneous events:
  - Push and pop in the same cycle: count is unchanged for NEW, and decreases by 1 for DUP or CONFLICT.
  - Push of the variable being popped in the same cycle is classified NEW and re-enqueued.
- Latency:
  - A NEW push into an empty queue in cycle N gives out_valid=1 in cycle N+1, with the entry at the head.
  - count, full and empty update on the edge that ends the cycle.
- Conflict:
  - Sticky until reset or flush.
  - While set, in_ready=0 and out_valid=0, so no pushes or pops occur; FIFO contents are frozen.
  - conflict_var holds the first offender.
- Full:
  - in_ready=0 even for a would-be DUP; the upstream stage stalls.
  - A pop in the same cycle does not raise in_ready combinationally.
- Empty: out_valid=0; out_ready is ignored.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble.
- Flush or reset mid-operation: every in-flight entry and pending bit is lost on that edge. A same-cycle push or pop has no effect.

Test Plan:
- Reset, then push (var=5,val=1) with out_ready=0. Required: next cycle out_valid=1, out_var=5, out_value=1, count=1. Push (5,1) again: count stays 1 (DUP).
- Push (7,0), then push (7,1). Required: conflict=1 and conflict_var=7 next cycle; in_ready=0; out_valid=0; count=1. Assert flush: next cycle conflict=0, count=0, empty=1, in_ready=1.
- Push vars 0..15 (val=0), out_ready=0. Required: full=1, count=16, in_ready=0. Hold in_valid with var=20: no entry is taken.
- Full queue, then out_ready=1 for 16 cycles. Required: heads pop in order 0..15, empty=1. Push 20 more distinct vars while popping: order is preserved across pointer wrap.
- Single entry (9,1), with pop and push (9,0) in the same cycle. Required: no conflict; next cycle out_var=9, out_value=0, count=1.
- Queue with 3 entries and conflict=0; assert reset together with in_valid=1 and out_ready=1. Required: next cycle count=0, empty=1, out_valid=0, conflict=0, pending map clear (a subsequent push of an earlier var is NEW).
